// File: rtl/vga_timing_gen.sv
// 640x480@60 pixel timing source: DrawX/DrawY counters, display enable and
// sync pulses delayed to line up with renderer RGB, plus line/frame strobes
// and a free-running frame counter.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter int unsigned PIPE_DELAY = 2
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] HLast    = 10'(H_TOTAL - 1);
    localparam logic [9:0] VLast    = 10'(V_TOTAL - 1);
    localparam logic [9:0] HVis     = 10'(H_VISIBLE);
    localparam logic [9:0] VVis     = 10'(V_VISIBLE);
    localparam logic [9:0] HSyncBeg = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HSyncEnd = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VSyncBeg = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VSyncEnd = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       h_wrap, v_wrap;
    logic       blank_raw, hs_raw, vs_raw;
    logic       line_start_q, frame_start_q;
    logic [7:0] frame_count_q;

    // Next counter position and raw timing decode of the current position.
    always_comb begin
        h_wrap = (hc_q == HLast);
        v_wrap = (vc_q == VLast);
        hc_d   = hc_q + 10'd1;
        vc_d   = vc_q;
        if (h_wrap) begin
            hc_d = 10'd0;
            vc_d = v_wrap ? 10'd0 : vc_q + 10'd1;
        end
        blank_raw = (hc_q < HVis) && (vc_q < VVis);
        hs_raw    = !((hc_q >= HSyncBeg) && (hc_q < HSyncEnd));
        vs_raw    = !((vc_q >= VSyncBeg) && (vc_q < VSyncEnd));
    end

    // Pixel/line counters and the strobes that mark a wrap into column 0.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc_q          <= 10'd0;
            vc_q          <= 10'd0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            line_start_q  <= h_wrap;
            frame_start_q <= h_wrap && v_wrap;
            if (h_wrap && v_wrap) begin
                frame_count_q <= frame_count_q + 8'd1;
            end
        end
    end

    if (PIPE_DELAY == 0) begin : g_comb
        assign blank = blank_raw;
        assign hs    = hs_raw;
        assign vs    = vs_raw;
    end else begin : g_pipe
        // Bit 0 holds the newest sample; the oldest drives the outputs.
        logic [PIPE_DELAY-1:0] blank_q, hs_q, vs_q;

        // Delay line advancing every clock, reset to the inactive levels.
        always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
                blank_q <= '0;
                hs_q    <= '1;
                vs_q    <= '1;
            end else begin
                blank_q <= PIPE_DELAY'({blank_q, blank_raw});
                hs_q    <= PIPE_DELAY'({hs_q, hs_raw});
                vs_q    <= PIPE_DELAY'({vs_q, vs_raw});
            end
        end

        assign blank = blank_q[PIPE_DELAY-1];
        assign hs    = hs_q[PIPE_DELAY-1];
        assign vs    = vs_q[PIPE_DELAY-1];
    end

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance (delay 2), a zero-delay
// instance and a shrunken-geometry instance (delay 3) for frame-level checks.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       blank;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } exp_t;

    localparam int SmallFrame = 16 * 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] b_x, b_y, z_x, z_y, s_x, s_y;
    logic       b_bl, b_hs, b_vs, b_ls, b_fs;
    logic       z_bl, z_hs, z_vs, z_ls, z_fs;
    logic       s_bl, s_hs, s_vs, s_ls, s_fs;
    logic [7:0] b_fc, z_fc, s_fc;

    vga_timing_gen #(.PIPE_DELAY(2)) u_big (
        .vga_clk(clk), .reset_n(rst_n), .DrawX(b_x), .DrawY(b_y), .blank(b_bl),
        .hs(b_hs), .vs(b_vs), .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
    );

    vga_timing_gen #(.PIPE_DELAY(0)) u_zero (
        .vga_clk(clk), .reset_n(rst_n), .DrawX(z_x), .DrawY(z_y), .blank(z_bl),
        .hs(z_hs), .vs(z_vs), .line_start(z_ls), .frame_start(z_fs), .frame_count(z_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .PIPE_DELAY(3)
    ) u_small (
        .vga_clk(clk), .reset_n(rst_n), .DrawX(s_x), .DrawY(s_y), .blank(s_bl),
        .hs(s_hs), .vs(s_vs), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
    );

    exp_t act_big, act_zero, act_small;
    assign act_big   = {b_x, b_y, b_bl, b_hs, b_vs, b_ls, b_fs, b_fc};
    assign act_zero  = {z_x, z_y, z_bl, z_hs, z_vs, z_ls, z_fs, z_fc};
    assign act_small = {s_x, s_y, s_bl, s_hs, s_vs, s_ls, s_fs, s_fc};

    exp_t sb_big[$];
    exp_t sb_zero[$];
    exp_t sb_small[$];

    int tests = 0;
    int fails = 0;
    int n = 0;  // clocks since reset release

    // Reference timing at n clocks after release.
    function automatic exp_t model(int cyc, int hv, int hf, int hsw, int hb,
                                   int vv, int vf, int vsw, int vb, int d);
        int ht = hv + hf + hsw + hb;
        int vt = vv + vf + vsw + vb;
        int m, px, py;
        exp_t e;
        e.x  = 10'(cyc % ht);
        e.y  = 10'((cyc / ht) % vt);
        e.ls = (cyc > 0) && (cyc % ht == 0);
        e.fs = (cyc > 0) && (cyc % (ht * vt) == 0);
        e.fc = 8'((cyc / (ht * vt)) % 256);
        if (cyc < d) begin
            e.blank = 1'b0;
            e.hs    = 1'b1;
            e.vs    = 1'b1;
        end else begin
            m  = cyc - d;
            px = m % ht;
            py = (m / ht) % vt;
            e.blank = (px < hv) && (py < vv);
            e.hs    = !((px >= hv + hf) && (px < hv + hf + hsw));
            e.vs    = !((py >= vv + vf) && (py < vv + vf + vsw));
        end
        return e;
    endfunction

    task automatic push_expected();
        sb_big.push_back(model(n, 640, 16, 96, 48, 480, 10, 2, 33, 2));
        sb_zero.push_back(model(n, 640, 16, 96, 48, 480, 10, 2, 33, 0));
        sb_small.push_back(model(n, 8, 2, 3, 3, 6, 1, 2, 2, 3));
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        n++;
    endtask

    task automatic test_reset();
        exp_t rst_e;
        rst_e = '{x: 10'd0, y: 10'd0, blank: 1'b0, hs: 1'b1, vs: 1'b1,
                  ls: 1'b0, fs: 1'b0, fc: 8'd0};
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (act_big !== rst_e) begin
            fails++;
            $display("FAIL reset_big got %h want %h", act_big, rst_e);
        end
        tests++;
        if (act_small !== rst_e) begin
            fails++;
            $display("FAIL reset_small got %h want %h", act_small, rst_e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n = 0;
    endtask

    task automatic test_line();
        exp_t e;
        logic prev_bhs = 1'b1, prev_bbl = 1'b0, prev_zhs = 1'b1, prev_zbl = 1'b0;
        int   b_hs_fall_x = -1, b_bl_fall_x = -1, z_hs_fall_x = -1, z_bl_fall_x = -1;
        int   b_hs_low = 0, b_ls_cnt = 0;
        for (int i = 0; i < 1700; i++) begin
            push_expected();
            e = sb_big.pop_front();
            tests++;
            if (act_big !== e) begin
                fails++;
                $display("FAIL line_big n=%0d got %h want %h", n, act_big, e);
            end
            e = sb_zero.pop_front();
            tests++;
            if (act_zero !== e) begin
                fails++;
                $display("FAIL line_zero n=%0d got %h want %h", n, act_zero, e);
            end
            e = sb_small.pop_front();
            tests++;
            if (act_small !== e) begin
                fails++;
                $display("FAIL line_small n=%0d got %h want %h", n, act_small, e);
            end
            if (prev_bhs && !b_hs && b_hs_fall_x < 0) b_hs_fall_x = int'(b_x);
            if (prev_bbl && !b_bl && b_bl_fall_x < 0) b_bl_fall_x = int'(b_x);
            if (prev_zhs && !z_hs && z_hs_fall_x < 0) z_hs_fall_x = int'(z_x);
            if (prev_zbl && !z_bl && z_bl_fall_x < 0) z_bl_fall_x = int'(z_x);
            if (n < 800 && !b_hs) b_hs_low++;
            if (b_ls) b_ls_cnt++;
            prev_bhs = b_hs;
            prev_bbl = b_bl;
            prev_zhs = z_hs;
            prev_zbl = z_bl;
            tick();
        end
        tests++;
        if (b_hs_fall_x !== 658) begin
            fails++;
            $display("FAIL hs_fall_x_delay2 got %0d want 658", b_hs_fall_x);
        end
        tests++;
        if (b_bl_fall_x !== 642) begin
            fails++;
            $display("FAIL blank_fall_x_delay2 got %0d want 642", b_bl_fall_x);
        end
        tests++;
        if (z_hs_fall_x !== 656) begin
            fails++;
            $display("FAIL hs_fall_x_delay0 got %0d want 656", z_hs_fall_x);
        end
        tests++;
        if (z_bl_fall_x !== 640) begin
            fails++;
            $display("FAIL blank_fall_x_delay0 got %0d want 640", z_bl_fall_x);
        end
        tests++;
        if (b_hs_low !== 96) begin
            fails++;
            $display("FAIL hs_low_width got %0d want 96", b_hs_low);
        end
        tests++;
        if (b_ls_cnt !== 2) begin
            fails++;
            $display("FAIL line_start_count got %0d want 2", b_ls_cnt);
        end
    endtask

    // Runs the small instance well past 256 frames so frame_count wraps.
    task automatic test_frames();
        exp_t e;
        int   fs_cnt = 0, vs_run = 0, vs_last = 0, vs_runs = 0;
        int   n_start = n;
        while (n <= 256 * SmallFrame + 20) begin
            push_expected();
            e = sb_small.pop_front();
            tests++;
            if (act_small !== e) begin
                fails++;
                $display("FAIL frames_small n=%0d got %h want %h", n, act_small, e);
            end
            e = sb_big.pop_front();
            tests++;
            if (act_big !== e) begin
                fails++;
                $display("FAIL frames_big n=%0d got %h want %h", n, act_big, e);
            end
            void'(sb_zero.pop_front());
            if (s_fs) fs_cnt++;
            if (!s_vs) begin
                vs_run++;
            end else if (vs_run > 0) begin
                vs_last = vs_run;
                vs_runs++;
                vs_run  = 0;
            end
            tick();
        end
        tests++;
        if (fs_cnt !== 256 - n_start / SmallFrame) begin
            fails++;
            $display("FAIL frame_start_count got %0d want %0d", fs_cnt,
                     256 - n_start / SmallFrame);
        end
        tests++;
        if (vs_runs < 2 || vs_last !== 32) begin
            fails++;
            $display("FAIL vs_low_width got %0d (runs %0d) want 32", vs_last, vs_runs);
        end
    endtask

    task automatic test_async_reset();
        exp_t e, rst_e;
        int   guard = 0, fs_cnt = 0;
        rst_e = '{x: 10'd0, y: 10'd0, blank: 1'b0, hs: 1'b1, vs: 1'b1,
                  ls: 1'b0, fs: 1'b0, fc: 8'd0};
        while (!(s_x == 10'd5 && s_y == 10'd4) && guard < 400) begin
            tick();
            guard++;
        end
        tests++;
        if (guard >= 400) begin
            fails++;
            $display("FAIL mid_frame_wait got timeout want x=5 y=4");
        end
        #3;
        rst_n = 1'b0;
        #1;
        tests++;
        if (act_small !== rst_e) begin
            fails++;
            $display("FAIL async_reset_small got %h want %h", act_small, rst_e);
        end
        tests++;
        if (act_big !== rst_e) begin
            fails++;
            $display("FAIL async_reset_big got %h want %h", act_big, rst_e);
        end
        tests++;
        if ({z_x, z_y, z_fc} !== 28'd0) begin
            fails++;
            $display("FAIL async_reset_zero got %h want 0", {z_x, z_y, z_fc});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n = 0;
        sb_big.delete();
        sb_zero.delete();
        sb_small.delete();
        for (int i = 0; i < SmallFrame + 8; i++) begin
            push_expected();
            e = sb_small.pop_front();
            tests++;
            if (act_small !== e) begin
                fails++;
                $display("FAIL restart_small n=%0d got %h want %h", n, act_small, e);
            end
            e = sb_big.pop_front();
            tests++;
            if (act_big !== e) begin
                fails++;
                $display("FAIL restart_big n=%0d got %h want %h", n, act_big, e);
            end
            void'(sb_zero.pop_front());
            if (s_fs) fs_cnt++;
            tick();
        end
        tests++;
        if (fs_cnt !== 1) begin
            fails++;
            $display("FAIL restart_frame_start_count got %0d want 1", fs_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frames();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
